// File: rtl/spi_cmd_parser.sv
// SPI command parser: decodes opcode/address/payload frames into addressed byte writes
// queued through a small FIFO, with sticky error status returned to the SPI transmitter.
module spi_cmd_parser #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              clr_status,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready,
  output logic [7:0]        status,
  output logic              busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StOpcode,
    StAddrHi,
    StAddrLo,
    StData,
    StDiscard
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              overflow_q, overflow_d;
  logic              bad_opcode_q, bad_opcode_d;
  logic [3:0]        frame_cnt_q, frame_cnt_d;

  logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];
  logic [7:0]        mem_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [PtrW:0]     count_q;

  logic push_req, push, pop, full, empty;
  logic set_overflow, set_bad, cnt_inc;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign pop   = wr_en && wr_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push         = push_req && (!full || pop);
  assign set_overflow = push_req && full && !pop;

  always_comb begin
    state_d   = state_q;
    addr_hi_d = addr_hi_q;
    addr_d    = addr_q;
    push_req  = 1'b0;
    set_bad   = 1'b0;
    cnt_inc   = 1'b0;
    if (frame_start) begin
      // A new chip-select aborts whatever was in progress; any byte this cycle is dropped.
      state_d = StOpcode;
    end else begin
      if (rx_valid) begin
        case (state_q)
          StOpcode: begin
            if (rx_data == 8'h01) begin
              state_d = StAddrHi;
            end else begin
              state_d = StDiscard;
              set_bad = (rx_data != 8'h00);
            end
          end
          StAddrHi: begin
            addr_hi_d = rx_data;
            state_d   = StAddrLo;
          end
          StAddrLo: begin
            addr_d  = ADDR_W'({addr_hi_q, rx_data});
            state_d = StData;
          end
          StData: begin
            push_req = 1'b1;
            addr_d   = addr_q + ADDR_W'(1);
          end
          default: ;
        endcase
      end
      if (frame_end) begin
        state_d = StIdle;
        cnt_inc = (state_q == StData);
      end
    end
  end

  always_comb begin
    overflow_d   = overflow_q;
    bad_opcode_d = bad_opcode_q;
    frame_cnt_d  = frame_cnt_q;
    if (clr_status) begin
      overflow_d   = 1'b0;
      bad_opcode_d = 1'b0;
    end
    // Set events take precedence over a simultaneous clear.
    if (set_overflow) overflow_d = 1'b1;
    if (set_bad) bad_opcode_d = 1'b1;
    if (cnt_inc) frame_cnt_d = frame_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_hi_q    <= 8'h00;
      addr_q       <= '0;
      overflow_q   <= 1'b0;
      bad_opcode_q <= 1'b0;
      frame_cnt_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      addr_hi_q    <= addr_hi_d;
      addr_q       <= addr_d;
      overflow_q   <= overflow_d;
      bad_opcode_q <= bad_opcode_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero while idle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        mem_addr_q[wptr_q] <= addr_q;
        mem_data_q[wptr_q] <= rx_data;
        wptr_q             <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: ;
      endcase
    end
  end

  assign wr_en   = !empty;
  assign wr_addr = mem_addr_q[rptr_q];
  assign wr_data = mem_data_q[rptr_q];
  assign status  = {overflow_q, bad_opcode_q, 2'b00, frame_cnt_q};
  assign busy    = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Bench for spi_cmd_parser: frame-level driver feeding a write scoreboard, with a
// separate monitor that checks every presented head entry against the expected queue.
module tb_spi_cmd_parser;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, frame_start, frame_end, rx_valid, clr_status, wr_ready;
  logic [7:0]  rx_data;
  logic        wr_en, busy;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data, status;

  spi_cmd_parser #(
    .ADDR_W    (16),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .clr_status (clr_status),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .status     (status),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  bit         m_ovf, m_bad;
  logic [3:0] m_cnt;
  int         rdy_mode;
  bit         rand_clr_en;
  logic [7:0] fb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_status(input string name);
    check(name, {24'h0, status}, {24'h0, m_ovf, m_bad, 2'b00, m_cnt});
  endtask

  // Monitor: the DUT FIFO must mirror the expected-write queue at every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      check("wr_en", {31'h0, wr_en}, {31'h0, exp_q.size() != 0});
      if (wr_en && exp_q.size() > 0) begin
        check("wr_addr", {16'h0, wr_addr}, {16'h0, exp_q[0].a});
        check("wr_data", {24'h0, wr_data}, {24'h0, exp_q[0].d});
        if (wr_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus, called at posedge+1. The flags say what the byte means
  // at frame level; the model decides acceptance as a bounded queue of DEPTH entries.
  task automatic step(input logic fs, input logic fe, input logic rv, input logic [7:0] d,
                      input logic clr, input bit is_opc, input bit is_pay,
                      input logic [15:0] paddr, input bit cnt_inc);
    bit   set_ovf, set_bad, have_pend, clr_eff;
    ent_t pend;
    int   sz;
    set_ovf   = 0;
    set_bad   = 0;
    have_pend = 0;
    pend      = '0;
    clr_eff   = clr || (rand_clr_en && $urandom_range(0, 15) == 0);
    frame_start = fs;
    frame_end   = fe;
    rx_valid    = rv;
    rx_data     = d;
    clr_status  = clr_eff;
    if (rdy_mode == 2) wr_ready = ($urandom_range(0, 1) == 1);
    else wr_ready = (rdy_mode == 1);
    if (rv && !fs) begin
      if (is_opc && d != 8'h00 && d != 8'h01) set_bad = 1;
      if (is_pay) begin
        sz = exp_q.size();
        if (sz < DEPTH || (sz > 0 && wr_ready)) begin
          have_pend = 1;
          pend.a    = paddr;
          pend.d    = d;
        end else begin
          set_ovf = 1;
        end
      end
    end
    if (fe && !fs && cnt_inc) m_cnt = m_cnt + 4'd1;
    m_ovf = set_ovf ? 1'b1 : (clr_eff ? 1'b0 : m_ovf);
    m_bad = set_bad ? 1'b1 : (clr_eff ? 1'b0 : m_bad);
    @(posedge clk);
    #1;
    if (have_pend) exp_q.push_back(pend);
    frame_start = 0;
    frame_end   = 0;
    rx_valid    = 0;
    clr_status  = 0;
  endtask

  task automatic step_idle();
    step(0, 0, 0, 8'h00, 0, 0, 0, 16'h0, 0);
  endtask

  // endk: 0 = separate frame_end, 1 = frame_end with last byte, 2 = no frame_end (abort)
  task automatic send_frame(input int endk, input int maxgap, input bit noise);
    int          n;
    bit          wr_frame, pay, last, coinc;
    logic [15:0] base, pa;
    n        = fb.size();
    wr_frame = (n >= 3) && (fb[0] == 8'h01);
    base     = wr_frame ? {fb[1], fb[2]} : 16'h0;
    step(1, 0, noise && ($urandom_range(0, 1) == 1), 8'($urandom), 0, 0, 0, 16'h0, 0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) step_idle();
      pay   = wr_frame && (i >= 3);
      pa    = base + 16'(i - 3);
      last  = (i == n - 1);
      coinc = last && (endk == 1);
      step(0, coinc, 1, fb[i], 0, i == 0, pay, pa, coinc && pay);
    end
    if (endk == 0) begin
      repeat ($urandom_range(0, maxgap)) step_idle();
      step(0, 1, 0, 8'h00, 0, 0, 0, 16'h0, wr_frame);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step_idle();
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d entries still pending, want 0", exp_q.size());
    end
  endtask

  task automatic load(input logic [7:0] b[]);
    fb.delete();
    foreach (b[i]) fb.push_back(b[i]);
  endtask

  initial begin
    int op, n, k, endk;
    logic [7:0] payload10[];
    rst = 1; frame_start = 0; frame_end = 0; rx_valid = 0; rx_data = 0;
    clr_status = 0; wr_ready = 0;
    m_ovf = 0; m_bad = 0; m_cnt = 0; rdy_mode = 1; rand_clr_en = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", {31'h0, wr_en}, 32'h0);
    check("rst_wr_addr", {16'h0, wr_addr}, 32'h0);
    check("rst_wr_data", {24'h0, wr_data}, 32'h0);
    check("rst_status", {24'h0, status}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst = 0;
    step_idle();

    // Basic write frame
    load('{8'h01, 8'h12, 8'h34, 8'hAA, 8'hBB, 8'hCC});
    send_frame(0, 0, 0);
    drain();
    check("t1_status", {24'h0, status}, 32'h01);
    check("t1_busy", {31'h0, busy}, 32'h0);

    // Address wrap
    load('{8'h01, 8'hFF, 8'hFF, 8'h11, 8'h22});
    send_frame(0, 0, 0);
    drain();
    check_status("t2_status");

    // Back-pressure and overflow
    rdy_mode = 0;
    payload10 = new[13];
    payload10[0] = 8'h01; payload10[1] = 8'h20; payload10[2] = 8'h00;
    for (int i = 3; i < 13; i++) payload10[i] = 8'(8'h40 + i);
    load(payload10);
    send_frame(0, 0, 0);
    repeat (3) step_idle();
    check("t3_status", {24'h0, status}, 32'h83);
    check("t3_wr_en", {31'h0, wr_en}, 32'h1);
    check("t3_busy", {31'h0, busy}, 32'h1);
    rdy_mode = 1;
    drain();

    // Bad opcode, then clear
    load('{8'h7E, 8'h01, 8'h02, 8'h03});
    send_frame(0, 0, 0);
    check("t4_status", {24'h0, status}, 32'hC3);
    step(0, 0, 0, 8'h00, 1, 0, 0, 16'h0, 0);
    check("t4_clr", {24'h0, status}, 32'h03);

    // Abort by a new frame_start
    load('{8'h01, 8'h00, 8'h10, 8'h55});
    send_frame(2, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 0, 16'h0, 0);
    drain();
    check("t5_status", {24'h0, status}, 32'h03);
    check("t5_busy_opcode", {31'h0, busy}, 32'h1);
    step(0, 1, 0, 8'h00, 0, 0, 0, 16'h0, 0);
    check("t5_busy_idle", {31'h0, busy}, 32'h0);
    check_status("t5_status_end");

    // Reset with entries pending
    rdy_mode = 0;
    load('{8'h01, 8'h40, 8'h00, 8'hA1, 8'hA2, 8'hA3});
    send_frame(0, 0, 0);
    #2;
    rst = 1;
    exp_q.delete();
    m_ovf = 0; m_bad = 0; m_cnt = 0;
    #1;
    check("t6_wr_en", {31'h0, wr_en}, 32'h0);
    check("t6_busy", {31'h0, busy}, 32'h0);
    check("t6_status", {24'h0, status}, 32'h0);
    check("t6_wr_addr", {16'h0, wr_addr}, 32'h0);
    @(posedge clk);
    #1;
    rst = 0;

    // Randomized frames
    rdy_mode = 2;
    rand_clr_en = 1;
    endk = 0;
    for (int f = 0; f < 40; f++) begin
      if (endk != 2) step(0, 0, ($urandom_range(0, 3) == 0), 8'($urandom), 0, 0, 0, 16'h0, 0);
      k = $urandom_range(0, 9);
      op = (k < 7) ? 1 : ((k == 7) ? 0 : int'($urandom_range(0, 255)));
      n = $urandom_range(0, 13);
      fb.delete();
      for (int i = 0; i < n; i++) fb.push_back((i == 0) ? 8'(op) : 8'($urandom));
      k = $urandom_range(0, 5);
      endk = (k <= 3) ? 0 : ((k == 5) ? 2 : 1);
      if (endk == 1 && (n == 0 || (n == 3 && fb[0] == 8'h01))) endk = 0;
      send_frame(endk, 2, 1);
      check_status("rand_status");
    end
    rand_clr_en = 0;
    step(0, 1, 0, 8'h00, 0, 0, 0, 16'h0, 0);
    drain();
    check("final_busy", {31'h0, busy}, 32'h0);
    check_status("final_status");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule
